// File: rtl/nco_spi_multichannel_rx.sv
// SPI slave that latches addressed NCO tuning words, one per channel, in the i_clock domain.
// Define NCO_SPI_READBACK_EN to build the MISO readback shifter; otherwise o_MISO is tied low.
module nco_spi_multichannel_rx #(
    parameter int WORD_WIDTH   = 32,
    parameter int NUM_CHANNELS = 4,
    parameter int CPOL         = 0,
    parameter int CPHA         = 0,
    parameter int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_SCLK,
    input  logic                               i_CS,
    input  logic                               i_MOSI,
    output logic                               o_MISO,
    output logic [NUM_CHANNELS*WORD_WIDTH-1:0] o_freq_words,
    output logic                               o_update,
    output logic [CH_BITS-1:0]                 o_update_channel,
    output logic                               o_frame_error,
    output logic                               o_busy
);
    localparam int               FRAME_LEN    = 8 + WORD_WIDTH;
    localparam int               CNT_W        = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(7);
    localparam logic [7:0]       NUM_CH_C     = 8'(NUM_CHANNELS);
    localparam logic             SCLK_IDLE    = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam logic             SAMPLE_RISE  = ((CPOL ^ CPHA) == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_DATA   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t                  state_r, state_next;
    logic                    sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic                    cs_meta_r, cs_sync_r, cs_prev_r;
    logic                    mosi_meta_r, mosi_sync_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [7:0]              cmd_r;
    logic [WORD_WIDTH-1:0]   data_r;
    logic                    start_pend_r;
    logic                    sclk_rise_s, sclk_fall_s, sample_edge_s, sample_ok_s;
    logic                    cs_fall_s, cs_rise_s, addr_ok_s, frame_ok_s;

    // Two-flop synchronisers plus previous-value flops for edge detection.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sclk_meta_r <= SCLK_IDLE;
            sclk_sync_r <= SCLK_IDLE;
            sclk_prev_r <= SCLK_IDLE;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= i_SCLK;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            cs_meta_r   <= i_CS;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            mosi_meta_r <= i_MOSI;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign sclk_rise_s   = sclk_sync_r & ~sclk_prev_r;
    assign sclk_fall_s   = ~sclk_sync_r & sclk_prev_r;
    assign sample_edge_s = SAMPLE_RISE ? sclk_rise_s : sclk_fall_s;
    assign cs_fall_s     = ~cs_sync_r & cs_prev_r;
    assign cs_rise_s     = cs_sync_r & ~cs_prev_r;
    // A sample edge coinciding with CS release belongs to no frame.
    assign sample_ok_s   = sample_edge_s & ~cs_rise_s;
    assign addr_ok_s     = ({1'b0, cmd_r[6:0]} < NUM_CH_C);
    assign frame_ok_s    = (cnt_r == CNT_FRAME) && addr_ok_s;

    // FSM state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s || start_pend_r) state_next = ST_CMD;
                else                           state_next = ST_IDLE;
            end
            ST_CMD: begin
                if (cs_rise_s)                                   state_next = ST_COMMIT;
                else if (sample_ok_s && (cnt_r == CNT_CMD_LAST)) state_next = ST_DATA;
                else                                             state_next = ST_CMD;
            end
            ST_DATA: begin
                if (cs_rise_s) state_next = ST_COMMIT;
                else           state_next = ST_DATA;
            end
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Shift registers, edge counter, channel word bank and status pulses.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_r            <= {CNT_W{1'b0}};
            cmd_r            <= 8'h00;
            data_r           <= {WORD_WIDTH{1'b0}};
            start_pend_r     <= 1'b0;
            o_freq_words     <= {(NUM_CHANNELS*WORD_WIDTH){1'b0}};
            o_update         <= 1'b0;
            o_update_channel <= {CH_BITS{1'b0}};
            o_frame_error    <= 1'b0;
            o_busy           <= 1'b0;
        end else begin
            o_update      <= 1'b0;
            o_frame_error <= 1'b0;
            o_busy        <= (state_next != ST_IDLE);
            // Remember a new frame starting while the previous one commits.
            start_pend_r  <= (state_r == ST_COMMIT) && cs_fall_s;
            case (state_r)
                ST_IDLE: begin
                    cnt_r  <= {CNT_W{1'b0}};
                    data_r <= {WORD_WIDTH{1'b0}};
                end
                ST_CMD: begin
                    if (sample_ok_s) begin
                        cmd_r <= {cmd_r[6:0], mosi_sync_r};
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (sample_ok_s) begin
                        if (cnt_r < CNT_FRAME) data_r <= {data_r[WORD_WIDTH-2:0], mosi_sync_r};
                        if (cnt_r != CNT_MAX)  cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    if (frame_ok_s) begin
                        if (!cmd_r[7]) begin
                            for (int n = 0; n < NUM_CHANNELS; n++) begin
                                if (int'(cmd_r[6:0]) == n) o_freq_words[n*WORD_WIDTH +: WORD_WIDTH] <= data_r;
                            end
                            o_update         <= 1'b1;
                            o_update_channel <= cmd_r[CH_BITS-1:0];
                        end
                    end else begin
                        o_frame_error <= 1'b1;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

`ifdef NCO_SPI_READBACK_EN
    logic                  shift_edge_s, load_tx_s;
    logic [7:0]            cmd_next_s;
    logic [WORD_WIDTH-1:0] rd_word_s;
    logic [WORD_WIDTH-1:0] tx_sr_r;
    logic [CNT_W-1:0]      tx_left_r;

    assign shift_edge_s = SAMPLE_RISE ? sclk_fall_s : sclk_rise_s;
    assign cmd_next_s   = {cmd_r[6:0], mosi_sync_r};
    assign load_tx_s    = (state_r == ST_CMD) && sample_ok_s && (cnt_r == CNT_CMD_LAST);

    // Word addressed by the command byte completing on this sample edge.
    always_comb begin
        rd_word_s = {WORD_WIDTH{1'b0}};
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (int'(cmd_next_s[6:0]) == n) rd_word_s = o_freq_words[n*WORD_WIDTH +: WORD_WIDTH];
            else                            rd_word_s = rd_word_s;
        end
    end

    // Transmit shifter: loaded on the last command bit, advanced only on shift edges.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            tx_sr_r   <= {WORD_WIDTH{1'b0}};
            tx_left_r <= {CNT_W{1'b0}};
            o_MISO    <= 1'b0;
        end else if (load_tx_s) begin
            o_MISO <= 1'b0;
            if (cmd_next_s[7] && ({1'b0, cmd_next_s[6:0]} < NUM_CH_C)) begin
                tx_sr_r   <= rd_word_s;
                tx_left_r <= CNT_W'(WORD_WIDTH);
            end else begin
                tx_left_r <= {CNT_W{1'b0}};
            end
        end else if (state_r == ST_DATA) begin
            if (shift_edge_s) begin
                if (tx_left_r != {CNT_W{1'b0}}) begin
                    o_MISO    <= tx_sr_r[WORD_WIDTH-1];
                    tx_sr_r   <= {tx_sr_r[WORD_WIDTH-2:0], 1'b0};
                    tx_left_r <= tx_left_r - CNT_W'(1);
                end else begin
                    o_MISO <= 1'b0;
                end
            end
        end else begin
            o_MISO    <= 1'b0;
            tx_left_r <= {CNT_W{1'b0}};
        end
    end
`else
    assign o_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_nco_spi_multichannel_rx.sv
// Bench for nco_spi_multichannel_rx: a mode-0 and a mode-3 instance driven by a bit-banged SPI master,
// checked against a per-channel word model; MISO expectations follow NCO_SPI_READBACK_EN.
module tb_nco_spi_multichannel_rx;
    localparam int WW   = 32;
    localparam int NCH  = 4;
    localparam int HALF = 50;
`ifdef NCO_SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk0 = 1'b0, cs0 = 1'b1, mosi0 = 1'b0;
    logic         sclk1 = 1'b1, cs1 = 1'b1, mosi1 = 1'b0;
    logic         miso0, miso1, upd0, upd1, err0, err1, busy0, busy1;
    logic [127:0] fw0, fw1;
    logic [1:0]   ch0, ch1;
    int           checks = 0;
    int           errors = 0;
    int           upd_tot0 = 0, upd_tot1 = 0, err_tot0 = 0, err_tot1 = 0;
    int           ch_q0[$];
    int           ch_q1[$];
    logic [31:0]  model[2][NCH];

    always #5 clk = ~clk;

    nco_spi_multichannel_rx #(.WORD_WIDTH(WW), .NUM_CHANNELS(NCH), .CPOL(0), .CPHA(0)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_SCLK(sclk0), .i_CS(cs0), .i_MOSI(mosi0),
        .o_MISO(miso0), .o_freq_words(fw0), .o_update(upd0), .o_update_channel(ch0),
        .o_frame_error(err0), .o_busy(busy0));

    nco_spi_multichannel_rx #(.WORD_WIDTH(WW), .NUM_CHANNELS(NCH), .CPOL(1), .CPHA(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_SCLK(sclk1), .i_CS(cs1), .i_MOSI(mosi1),
        .o_MISO(miso1), .o_freq_words(fw1), .o_update(upd1), .o_update_channel(ch1),
        .o_frame_error(err1), .o_busy(busy1));

    // Pulse monitor: every high cycle counts, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (upd0) begin upd_tot0++; ch_q0.push_back(int'(ch0)); end
        if (upd1) begin upd_tot1++; ch_q1.push_back(int'(ch1)); end
        if (err0) err_tot0++;
        if (err1) err_tot1++;
    end

    function automatic logic get_upd(input int m);   return (m == 0) ? upd0 : upd1;   endfunction
    function automatic logic get_err(input int m);   return (m == 0) ? err0 : err1;   endfunction
    function automatic logic get_busy(input int m);  return (m == 0) ? busy0 : busy1; endfunction
    function automatic logic get_miso(input int m);  return (m == 0) ? miso0 : miso1; endfunction
    function automatic logic [1:0] get_ch(input int m);   return (m == 0) ? ch0 : ch1; endfunction
    function automatic logic [127:0] get_fw(input int m); return (m == 0) ? fw0 : fw1; endfunction
    function automatic int get_upd_tot(input int m); return (m == 0) ? upd_tot0 : upd_tot1; endfunction
    function automatic int get_err_tot(input int m); return (m == 0) ? err_tot0 : err_tot1; endfunction
    function automatic int get_q_size(input int m);  return (m == 0) ? ch_q0.size() : ch_q1.size(); endfunction
    function automatic int get_q(input int m, input int idx);
        if (idx >= get_q_size(m)) return -1;
        return (m == 0) ? ch_q0[idx] : ch_q1[idx];
    endfunction

    function automatic logic [127:0] pack_model(input int m);
        logic [127:0] r;
        for (int c = 0; c < NCH; c++) r[c*WW +: WW] = model[m][c];
        return r;
    endfunction

    task automatic set_sclk(input int m, input logic v); if (m == 0) sclk0 = v; else sclk1 = v; endtask
    task automatic set_cs(input int m, input logic v);   if (m == 0) cs0 = v;   else cs1 = v;   endtask
    task automatic set_mosi(input int m, input logic v); if (m == 0) mosi0 = v; else mosi1 = v; endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int m = 0; m < 2; m++) begin
            check({tag, "_words"}, get_fw(m), 128'h0);
            check({tag, "_flags"}, 128'({get_upd(m), get_err(m), get_busy(m), get_miso(m), get_ch(m)}), 128'h0);
        end
    endtask

    // Master: CS low, command then ndata data bits MSB first; CS is left low. Mode 0 for m=0, mode 3 for m=1.
    task automatic spi_bits(input int m, input logic [7:0] cmd, input logic [63:0] data, input int ndata,
                            output logic [31:0] rx, output logic cmd_seen);
        logic b;
        rx = 32'h0;
        cmd_seen = 1'b0;
        set_cs(m, 1'b0);
        for (int i = 0; i < 8 + ndata; i++) begin
            b = (i < 8) ? cmd[7 - i] : data[ndata - 1 - (i - 8)];
            if (m == 0) begin
                set_mosi(m, b); #HALF; set_sclk(m, 1'b1);
            end else begin
                #HALF; set_sclk(m, 1'b0); set_mosi(m, b); #HALF; set_sclk(m, 1'b1);
            end
            if (i < 8) cmd_seen = cmd_seen | get_miso(m);
            else if (i < 8 + WW) rx = {rx[30:0], get_miso(m)};
            if (m == 0) begin #HALF; set_sclk(m, 1'b0); end
        end
        #HALF;
    endtask

    task automatic run_frame(input int m, input logic [7:0] cmd, input logic [63:0] data, input int ndata);
        logic [31:0] rx, exp_rx;
        logic        cmd_seen, in_range, exp_err, exp_upd;
        int          addr, u0, e0;
        addr     = int'(cmd[6:0]);
        in_range = (addr < NCH);
        exp_err  = !(in_range && (ndata == WW));
        exp_upd  = !exp_err && !cmd[7];
        exp_rx   = 32'h0;
        if (RB && cmd[7] && in_range) exp_rx = (ndata >= WW) ? model[m][addr] : (model[m][addr] >> (WW - ndata));
        @(negedge clk);
        u0 = get_upd_tot(m);
        e0 = get_err_tot(m);
        spi_bits(m, cmd, data, ndata, rx, cmd_seen);
        check("busy_in_frame", 128'(get_busy(m)), 128'(1'b1));
        set_cs(m, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("no_early_pulse", 128'({get_upd(m), get_err(m)}), 128'h0);
        @(posedge clk);
        #1;
        check("update_pulse", 128'(get_upd(m)), 128'(exp_upd));
        check("frame_error_pulse", 128'(get_err(m)), 128'(exp_err));
        if (exp_upd) begin
            check("update_channel", 128'(get_ch(m)), 128'(cmd[1:0]));
            model[m][addr] = data[31:0];
        end
        repeat (4) @(posedge clk);
        #1;
        check("busy_after", 128'(get_busy(m)), 128'h0);
        check("update_count", 128'(get_upd_tot(m) - u0), 128'(exp_upd));
        check("error_count", 128'(get_err_tot(m) - e0), 128'(exp_err));
        check("words", get_fw(m), pack_model(m));
        check("miso_data", 128'(rx), 128'(exp_rx));
        check("miso_cmd_and_idle", 128'({cmd_seen, get_miso(m)}), 128'h0);
    endtask

    task automatic b2b(input int m, input logic [7:0] ca, input logic [31:0] da,
                       input logic [7:0] cb, input logic [31:0] db, input int gap);
        logic [31:0] rx;
        logic        seen;
        int          u0, q0;
        @(negedge clk);
        u0 = get_upd_tot(m);
        q0 = get_q_size(m);
        spi_bits(m, ca, {32'h0, da}, WW, rx, seen);
        set_cs(m, 1'b1);
        #gap;
        spi_bits(m, cb, {32'h0, db}, WW, rx, seen);
        set_cs(m, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        model[m][int'(ca[6:0])] = da;
        model[m][int'(cb[6:0])] = db;
        check("b2b_count", 128'(get_upd_tot(m) - u0), 128'd2);
        check("b2b_first_ch", 128'(get_q(m, q0)), 128'(int'(ca[6:0])));
        check("b2b_second_ch", 128'(get_q(m, q0 + 1)), 128'(int'(cb[6:0])));
        check("b2b_words", get_fw(m), pack_model(m));
    endtask

    initial begin
        logic [31:0] rx;
        logic        seen;
        for (int m = 0; m < 2; m++) for (int c = 0; c < NCH; c++) model[m][c] = 32'h0;

        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_frame(0, 8'h02, 64'hAABBCCDD, 32);
        check("ch2_written", fw0, 128'h00000000_AABBCCDD_00000000_00000000);
        run_frame(0, 8'h01, 64'h0000_0ABC, 12);
        run_frame(0, 8'h82, 64'h0, 32);
        run_frame(0, 8'h05, 64'h1, 32);

        // Reset in the middle of a write to channel 0.
        @(negedge clk);
        spi_bits(0, 8'h00, 64'hF, 4, rx, seen);
        rst = 1'b1;
        #1 check_all_zero("midframe_reset");
        for (int m = 0; m < 2; m++) for (int c = 0; c < NCH; c++) model[m][c] = 32'h0;
        set_cs(0, 1'b1);
        set_mosi(0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(0, 8'h00, 64'h10, 32);
        check("ch0_after_reset", 128'(fw0[31:0]), 128'h10);

        b2b(1, 8'h01, 32'h12345678, 8'h03, 32'hFFFFFFFF, 2 * HALF);
        b2b(0, 8'h00, 32'h0BADF00D, 8'h02, 32'h55AA55AA, 10);
        b2b(1, 8'h02, 32'hCAFEBABE, 8'h00, 32'h01020304, 10);
        run_frame(1, 8'h83, 64'h0, 32);

        for (int k = 0; k < 20; k++) begin
            logic [7:0]  cmd;
            logic [63:0] d;
            int          nd;
            cmd = {($urandom_range(0, 3) == 0), 7'($urandom_range(0, 5))};
            d   = {$urandom, $urandom};
            nd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : WW;
            run_frame(k % 2, cmd, d, nd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nco_spi_multichannel_rx.md
Name: nco_spi_multichannel_rx

Overview:
Parametrised SPI slave that receives addressed frequency-tuning words for a bank of NCO channels. It holds one latched word per channel. Generalises the single-word NCO SPI receiver with:
- per-channel addressing
- selectable SPI mode (CPOL/CPHA)
- frame-length checking
- optional MISO readback
Sits between the MCU SPI port and the NCO phase accumulators, in the system clock domain.

Parameters:
WORD_WIDTH, 32, bits per tuning word (8..64)
NUM_CHANNELS, 4, number of NCO channels (1..128)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
CH_BITS, $clog2(NUM_CHANNELS) (min 1), width of channel index outputs

Ports:
i_clock  in  1  system clock; must be at least 8x SCLK frequency
i_reset  in  1  asynchronous, active-high reset
i_SCLK  in  1  SPI clock (asynchronous to i_clock)
i_CS  in  1  SPI chip select, active low
i_MOSI  in  1  SPI data in
o_MISO  out  1  SPI data out (readback)
o_freq_words  out  NUM_CHANNELS*WORD_WIDTH  latched words; channel n at [n*WORD_WIDTH +: WORD_WIDTH]
o_update  out  1  one-cycle pulse when a channel word is committed
o_update_channel  out  CH_BITS  index of the committed channel; valid while o_update=1
o_frame_error  out  1  one-cycle pulse on a rejected frame
o_busy  out  1  high while a frame is in progress

Behaviour:
- Reset (async, i_reset=1): all o_freq_words=0, o_MISO=0, o_update=0, o_update_channel=0, o_frame_error=0, o_busy=0, state IDLE, bit counter 0. Reset mid-frame aborts the frame. No partial word is ever committed.
- Input synchronisation: i_SCLK, i_CS, i_MOSI each pass through a 2-flop synchroniser. Edges are detected on the synchronised signals. An SCLK edge acts 3 i_clock cycles after the pin edge.
- Sample edge:
  - CPOL^CPHA=0: synchronised SCLK rising.
  - CPOL^CPHA=1: SCLK falling.
  - The shift edge is the opposite edge.
- Frame format, MSB first:
  - Command byte: bit7 = R/nW, bits[6:0] = channel address.
  - Followed by WORD_WIDTH data bits.
  - A valid frame has exactly 8+WORD_WIDTH sample edges.
- State machine:
  - IDLE: synchronised CS falling -> CMD; o_busy=1; counter cleared. SCLK edges in IDLE are ignored.
  - CMD: shift MOSI on each sample edge. After the 8th edge, latch the command, then -> DATA.
  - DATA: shift MOSI into a WORD_WIDTH shift register; count edges. Sample edges beyond 8+WORD_WIDTH are counted but not shifted.
  - Synchronised CS rising in CMD or DATA -> COMMIT.
  - COMMIT (one cycle), then -> IDLE with o_busy=0:
    - Write with count == 8+WORD_WIDTH and address < NUM_CHANNELS: the channel word updates and o_update=1 with o_update_channel=address, both in the same cycle. Other channels are unchanged.
    - Any other count, or an out-of-range address (read or write): o_frame_error=1 and no register changes.
    - Valid read: no pulse.
- Commit latency: o_update asserts 4 i_clock cycles after the i_CS pin rising edge.
- Readback (see Optional Feature):
  - For a read command, the selected word is loaded into the transmit shifter when the 8th sample edge occurs.
  - o_MISO presents the next data bit on each subsequent shift edge, MSB first.
  - o_MISO=0 in CMD, after the last bit, in IDLE, and for out-of-range reads.
- Mode independence: the shifter is updated on shift edges only, so data is valid before each master sample edge in both CPHA modes.
- Simultaneous events: CS rising in the same cycle as a sample edge ignores that sample edge.
- Back-to-back frames: a CS falling edge detected during COMMIT is honoured on the next cycle; no frame is lost.

Optional Feature:
Macro NCO_SPI_READBACK_EN.
- Defined: read commands return the stored word on o_MISO as described above.
- Undefined:
  - No transmit shifter is built and o_MISO is tied to 0.
  - Read commands with a valid address and length are consumed silently, with no pulses.
  - Out-of-range or wrong-length reads still pulse o_frame_error.

Test Plan:
1. Mode 0 (WORD_WIDTH=32, NUM_CHANNELS=4), write cmd 8'h02 + 32'hAABBCCDD, then raise CS -> channel 2 = 32'hAABBCCDD; o_update one cycle with o_update_channel=2; channels 0, 1, 3 stay 0.
2. Cmd 8'h01 + 12 data bits, then raise CS -> o_frame_error one cycle; o_update stays 0; channel 1 unchanged.
3. After test 1, with the macro defined, read cmd 8'h82 + 32 clocks -> o_MISO bits sampled by the master = 32'hAABBCCDD; no pulses.
4. Write cmd 8'h05 + 32'h00000001 -> o_frame_error=1; all channels unchanged. Without the macro, cmd 8'h82 -> o_MISO=0 throughout.
5. Assert i_reset after 12 SCLK bits of a write to channel 0 -> all outputs 0 immediately. A following full write of 8'h00 + 32'h00000010 -> channel 0 = 32'h10.
6. CPOL=1/CPHA=1 instance, back-to-back writes 8'h01+32'h12345678 and 8'h03+32'hFFFFFFFF separated by one SCLK period of CS high -> both commit: two o_update pulses with channels 1 then 3.
